pixel_frame_collector: RTL
==========================

PIXEL_FRAME_COLLECTOR -- requirements
Module: pixel_frame_collector

Interface
REQ-001 Parameter WORD_SIZE, default 8, pixel width in bits.
REQ-002 Parameter ROW_SIZE, default 540, pixels per row (image width).
REQ-003 Parameter IMAGE_HEIGHT, default 360, rows per frame.
REQ-004 Parameter SKIP_COUNT, default 0, leading valid pixels discarded per frame (filter pipeline fill).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse arming capture of one frame.
REQ-008 in_valid  input  1  in_pixel carries a filter output pixel this cycle.
REQ-009 in_pixel  input  WORD_SIZE  pixel from the convolution stage.
REQ-010 out_valid  output  1  out_pixel holds a readout pixel.
REQ-011 out_ready  input  1  downstream accepts out_pixel this cycle.
REQ-012 out_pixel  output  WORD_SIZE  readout pixel, raster order.
REQ-013 out_last  output  1  high with the final readout pixel of the frame.
REQ-014 busy  output  1  high in SKIP, CAPTURE or DRAIN.
REQ-015 frame_done  output  1  one-cycle pulse on acceptance of the last readout pixel.
REQ-016 overrun  output  1  sticky: in_valid seen while not in SKIP/CAPTURE after a start.

Function
REQ-017 The block SHALL implement states IDLE, SKIP, CAPTURE, DRAIN.
REQ-018 IDLE: start -> SKIP if SKIP_COUNT>0, else CAPTURE; other inputs ignored except overrun rule.
REQ-019 SKIP: each in_valid increments skip counter and discards pixel; on the SKIP_COUNT-th valid -> CAPTURE.
REQ-020 CAPTURE: each in_valid writes in_pixel to frame memory (ROW_SIZE*IMAGE_HEIGHT words) at address row*ROW_SIZE+col, then advances col.
REQ-021 col SHALL wrap from ROW_SIZE-1 to 0 and increment row in the same cycle.
REQ-022 Write at row=IMAGE_HEIGHT-1, col=ROW_SIZE-1 SHALL transition to DRAIN next cycle with counters cleared.
REQ-023 Cycles with in_valid low SHALL not change counters or memory (gaps tolerated, e.g. pixel every 2nd cycle).
REQ-024 DRAIN: read address starts at 0; out_valid asserts at most 2 cycles after DRAIN entry and holds until handshake.
REQ-025 A transfer occurs when out_valid and out_ready are both high; out_pixel SHALL remain stable while out_valid high and out_ready low.
REQ-026 With out_ready held high, DRAIN SHALL sustain one pixel per cycle after the first.
REQ-027 out_last SHALL be high only with address ROW_SIZE*IMAGE_HEIGHT-1.
REQ-028 Transfer with out_last -> frame_done pulse next... same cycle as the transfer, state -> IDLE, out_valid low next cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 in_valid in IDLE (after any start) or DRAIN SHALL drop the pixel and set overrun; overrun clears only on rst.
REQ-031 Readout pixel order SHALL equal capture order exactly (byte-identical raster dump).

Reset
REQ-032 rst SHALL force IDLE and clear row, col, skip and read counters in the cycle it is sampled, regardless of state.
REQ-033 During and after reset: out_valid=0, out_last=0, busy=0, frame_done=0, overrun=0, out_pixel=0.
REQ-034 Frame memory contents need not be reset; reset mid-CAPTURE or mid-DRAIN abandons the frame, no frame_done.

Verification
REQ-035 ROW_SIZE=4, IMAGE_HEIGHT=3, SKIP_COUNT=0; start, 12 valid pixels 0x00..0x0B back-to-back, out_ready=1 -> out_pixel 0x00..0x0B in order, out_last with 0x0B, one frame_done.
REQ-036 Same, pixels every 2nd cycle (in_valid alternating) -> identical readout; busy high from cycle after start to frame_done.
REQ-037 SKIP_COUNT=2; 14 valid pixels 0xA0..0xAD -> readout 0xA2..0xAD, 12 pixels.
REQ-038 Readout with out_ready toggled 1,0,0,1... -> out_pixel stable across stalls, no pixel lost or duplicated, 12 transfers total.
REQ-039 in_valid pulsed during DRAIN -> overrun=1 and stays 1, readout data unchanged; rst -> overrun=0.
REQ-040 rst asserted after 5 captured pixels, then start and full 12-pixel frame -> readout equals second frame only, exactly one frame_done.

Source files
------------

// File: rtl/pixel_frame_collector.sv
// Captures one frame of filter output pixels into a frame buffer, then streams
// the frame back out in raster order over a valid/ready interface.
module pixel_frame_collector #(
   parameter int WORD_SIZE    = 8,
   parameter int ROW_SIZE     = 540,
   parameter int IMAGE_HEIGHT = 360,
   parameter int SKIP_COUNT   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_pixel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_last,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun
);
   // Output handshake: a pixel moves when out_valid && out_ready in the same
   // cycle; out_pixel/out_last hold steady while out_valid is high and out_ready low.
   localparam int DEPTH = ROW_SIZE * IMAGE_HEIGHT;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int SW    = (SKIP_COUNT > 0) ? $clog2(SKIP_COUNT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} state_t;

   state_t               state;
   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic [SW-1:0]        skip_cnt;
   logic [AW-1:0]        rd_addr;
   logic [AW-1:0]        wr_addr;
   logic                 started;
   logic                 wr_en;
   logic                 col_end;
   logic                 row_end;
   logic                 xfer;
   logic [WORD_SIZE-1:0] mem [DEPTH];

   assign wr_addr    = AW'(row) * AW'(ROW_SIZE) + AW'(col);
   assign col_end    = (32'(col) == ROW_SIZE - 1);
   assign row_end    = (32'(row) == IMAGE_HEIGHT - 1);
   assign wr_en      = (state == CAPTURE) && in_valid;
   assign xfer       = out_valid && out_ready;
   assign frame_done = xfer && out_last;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_addr] <= in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         skip_cnt  <= '0;
         rd_addr   <= '0;
         started   <= 1'b0;
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pixel <= '0;
      end else begin
         // Pixels arriving when nothing is collecting are lost; flag it once armed.
         if (in_valid && started && (state == IDLE || state == DRAIN)) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  started  <= 1'b1;
                  col      <= '0;
                  row      <= '0;
                  skip_cnt <= '0;
                  if (SKIP_COUNT > 0) state <= SKIP;
                  else                state <= CAPTURE;
               end
            end
            SKIP: begin
               if (in_valid) begin
                  if (32'(skip_cnt) == SKIP_COUNT - 1) begin
                     skip_cnt <= '0;
                     state    <= CAPTURE;
                  end else begin
                     skip_cnt <= skip_cnt + 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (in_valid) begin
                  if (col_end) begin
                     col <= '0;
                     if (row_end) begin
                        row     <= '0;
                        rd_addr <= '0;
                        state   <= DRAIN;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (xfer && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= IDLE;
               end else if (!out_valid || out_ready) begin
                  // Refill the output register whenever it is empty or being taken.
                  out_pixel <= mem[rd_addr];
                  out_valid <= 1'b1;
                  out_last  <= (32'(rd_addr) == DEPTH - 1);
                  rd_addr   <= (32'(rd_addr) == DEPTH - 1) ? '0 : rd_addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
